// File: rtl/mem_stage.sv
// MEM stage of a 5-stage RV32 pipeline: EX/MEM register, data-memory handshake,
// load/store lane formatting and the MEM/WB register.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_reg_write,
  output logic [4:0]  mem_rd,
  output logic [31:0] mem_forward_value,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  function automatic size_t size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = SZ_B;
      3'b001, 3'b101: size_of = SZ_H;
      default:        size_of = SZ_W;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'd0, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

  logic        m_valid_r, m_read_r, m_write_r, m_regw_r;
  logic [4:0]  m_rd_r;
  logic [2:0]  m_f3_r;
  logic [31:0] m_alu_r, m_wd_r;

  state_t      state_r, next_state_s;
  size_t       size_s;
  logic [1:0]  off_s;
  logic        is_access_s, bad_align_s, misalign_s, is_load_s, rd_ok_s;
  logic        wb_regw_next_s;
  logic [31:0] wb_data_next_s;

  // EX/MEM pipeline register; frozen while the memory access is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_read_r  <= 1'b0;
      m_write_r <= 1'b0;
      m_regw_r  <= 1'b0;
      m_rd_r    <= 5'd0;
      m_f3_r    <= 3'd0;
      m_alu_r   <= 32'd0;
      m_wd_r    <= 32'd0;
    end else if (!mem_stall) begin
      m_valid_r <= ex_valid;
      m_read_r  <= ex_mem_read;
      m_write_r <= ex_mem_write;
      m_regw_r  <= ex_reg_write;
      m_rd_r    <= ex_rd;
      m_f3_r    <= ex_funct3;
      m_alu_r   <= ex_alu_result;
      m_wd_r    <= ex_write_data;
    end
  end

  // Access decode, alignment check and store/byte-enable formatting
  always_comb begin
    size_s      = size_of(m_f3_r);
    off_s       = m_alu_r[1:0];
    is_access_s = m_valid_r & (m_read_r | m_write_r);
    case (size_s)
      SZ_H:    bad_align_s = off_s[0];
      SZ_W:    bad_align_s = (off_s != 2'd0);
      default: bad_align_s = 1'b0;
    endcase
    misalign_s = is_access_s & bad_align_s;
    dmem_req   = is_access_s & ~bad_align_s;
    dmem_we    = m_write_r;
    dmem_addr  = {m_alu_r[31:2], 2'b00};
    case (size_s)
      SZ_B: begin
        dmem_wdata = {4{m_wd_r[7:0]}};
        dmem_be    = 4'b0001 << off_s;
      end
      SZ_H: begin
        dmem_wdata = {2{m_wd_r[15:0]}};
        dmem_be    = 4'b0011 << off_s;
      end
      default: begin
        dmem_wdata = m_wd_r;
        dmem_be    = 4'b1111;
      end
    endcase
    mem_stall = dmem_req & ~dmem_ready;
  end

  // Forwarding taps and MEM/WB next values; write wins over read
  always_comb begin
    is_load_s         = m_read_r & ~m_write_r;
    rd_ok_s           = m_valid_r & (m_rd_r != 5'd0);
    mem_reg_write     = rd_ok_s & m_regw_r & ~is_load_s;
    mem_rd            = m_rd_r;
    mem_forward_value = m_alu_r;
    wb_regw_next_s    = rd_ok_s & m_regw_r & ~m_write_r & ~misalign_s;
    if (is_load_s && !misalign_s) begin
      wb_data_next_s = load_extract(dmem_rdata, off_s, m_f3_r);
    end else begin
      wb_data_next_s = m_alu_r;
    end
  end

  // Handshake state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Handshake next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (dmem_req && !dmem_ready) next_state_s = WAIT;
        else                         next_state_s = IDLE;
      end
      WAIT: begin
        if (dmem_ready) next_state_s = IDLE;
        else            next_state_s = WAIT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // MEM/WB register; stall edges insert a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      misalign_err <= 1'b0;
    end else if (mem_stall) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      wb_valid     <= m_valid_r;
      wb_reg_write <= wb_regw_next_s;
      wb_rd        <= m_rd_r;
      wb_data      <= wb_data_next_s;
      misalign_err <= misalign_s;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage with an arithmetic reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_write_data;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, mem_reg_write, wb_valid, wb_reg_write, misalign_err;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_forward_value, wb_data;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_forward_value(mem_forward_value), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign_err(misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One instruction through MEM; waits = memory wait cycles if it accesses memory
  task automatic do_op(input logic rd_f, input logic wr_f, input logic rw_f,
                       input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] rdata, input int waits);
    int          sz, off, n;
    bit          access, mis, req, is_load;
    logic [31:0] lane, ld, exp_wd, exp_be, exp_wb;
    bit          exp_wbrw, exp_memrw;
    access  = rd_f || wr_f;
    sz      = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
    off     = int'(alu % 32'd4);
    mis     = access && ((alu % sz) != 0);
    req     = access && !mis;
    is_load = rd_f && !wr_f;
    lane    = rdata >> (8 * off);
    if (sz == 1) begin
      ld     = lane & 32'hFF;
      if (f3 < 3'd4 && ld >= 32'd128) ld = ld - 32'd256;
      exp_wd = (wd & 32'hFF) * 32'h01010101;
      exp_be = 32'd1 << off;
    end else if (sz == 2) begin
      ld     = lane & 32'hFFFF;
      if (f3 < 3'd4 && ld >= 32'd32768) ld = ld - 32'd65536;
      exp_wd = (wd & 32'hFFFF) * 32'h00010001;
      exp_be = 32'd3 << off;
    end else begin
      ld     = rdata;
      exp_wd = wd;
      exp_be = 32'd15;
    end
    exp_wb    = (is_load && !mis) ? ld : alu;
    exp_wbrw  = rw_f && rd != 5'd0 && !wr_f && !mis;
    exp_memrw = rw_f && rd != 5'd0 && !is_load;

    ex_valid = 1'b1; ex_mem_read = rd_f; ex_mem_write = wr_f; ex_reg_write = rw_f;
    ex_rd = rd; ex_funct3 = f3; ex_alu_result = alu; ex_write_data = wd;
    dmem_ready = 1'b0; dmem_rdata = $urandom;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_alu_result = $urandom; ex_write_data = $urandom;
    check("wb_idle_valid", wb_valid, 0);
    check("misalign_pulse_end", misalign_err, 0);
    check("mem_rd", mem_rd, rd);
    check("mem_fwd", mem_forward_value, alu);
    check("mem_reg_write", mem_reg_write, exp_memrw);
    check("dmem_req", dmem_req, req);
    if (req) begin
      check("dmem_addr", dmem_addr, alu & 32'hFFFFFFFC);
      check("dmem_be", dmem_be, exp_be);
      check("dmem_wdata", dmem_wdata, exp_wd);
      check("dmem_we", dmem_we, wr_f);
    end
    n = req ? waits : 0;
    for (int i = 0; i < n; i++) begin
      check("stall_wait", mem_stall, 1);
      @(posedge clk); #1;
      check("addr_stable", dmem_addr, alu & 32'hFFFFFFFC);
      check("wb_bubble", wb_valid, 0);
    end
    dmem_ready = req ? 1'b1 : 1'(($urandom % 2));
    dmem_rdata = rdata;
    #1;
    check("no_stall", mem_stall, 0);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    check("wb_valid", wb_valid, 1);
    check("wb_rd", wb_rd, rd);
    check("wb_data", wb_data, exp_wb);
    check("wb_reg_write", wb_reg_write, exp_wbrw);
    check("misalign_err", misalign_err, mis);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    rst = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    ex_rd = 5'd0; ex_funct3 = 3'd0; ex_alu_result = 32'd0; ex_write_data = 32'd0;
    dmem_ready = 1'b0; dmem_rdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rst_dmem_req", dmem_req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_regw", wb_reg_write, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_regw", mem_reg_write, 0);
    check("rst_mem_fwd", mem_forward_value, 0);
    check("rst_misalign", misalign_err, 0);

    do_op(1'b0, 1'b0, 1'b1, 5'd5, 3'b000, 32'h0000_1234, 32'd0, 32'd0, 0);          // ALU op
    do_op(1'b0, 1'b1, 1'b0, 5'd1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'd0, 0);  // SB
    do_op(1'b1, 1'b0, 1'b1, 5'd7, 3'b000, 32'h0000_2002, 32'd0, 32'h0080_0000, 2);  // LB
    do_op(1'b1, 1'b0, 1'b1, 5'd7, 3'b100, 32'h0000_2002, 32'd0, 32'h0080_0000, 2);  // LBU
    do_op(1'b1, 1'b0, 1'b1, 5'd9, 3'b010, 32'h0000_2001, 32'd0, 32'h1111_1111, 0);  // LW misaligned
    do_op(1'b1, 1'b0, 1'b1, 5'd0, 3'b010, 32'h0000_3000, 32'd0, 32'hDEAD_BEEF, 0);  // LW rd=0

    // Reset while waiting on memory, then a late ready
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
    ex_rd = 5'd3; ex_funct3 = 3'b010; ex_alu_result = 32'h0000_4000;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    check("wait_req", dmem_req, 1);
    check("wait_stall", mem_stall, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h5555_5555;
    #1;
    check("post_rst_req", dmem_req, 0);
    check("post_rst_stall", mem_stall, 0);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    check("late_ready_wb_valid", wb_valid, 0);
    check("late_ready_wb_regw", wb_reg_write, 0);
    do_op(1'b1, 1'b0, 1'b1, 5'd3, 3'b010, 32'h0000_4000, 32'd0, 32'hCAFE_F00D, 1);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      kind = int'($urandom % 4);
      case (kind)
        0:       do_op(1'b0, 1'b0, 1'($urandom % 2), 5'($urandom), 3'($urandom), a, $urandom, $urandom, 0);
        1:       do_op(1'b1, 1'b0, 1'b1, 5'($urandom), 3'($urandom), a, $urandom, $urandom, int'($urandom % 4));
        2:       do_op(1'b0, 1'b1, 1'b0, 5'($urandom), 3'($urandom), a, $urandom, $urandom, int'($urandom % 4));
        default: do_op(1'b1, 1'b1, 1'($urandom % 2), 5'($urandom), 3'($urandom), a, $urandom, $urandom, int'($urandom % 3));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
